// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and LSU writeback results onto one registered
// register-file write port. ALU results always win the port; LSU results
// are buffered in a small FIFO whose entries carry a live bit so that a
// younger ALU write to the same register can squash a stale queued load.
//
// LSU handshake: lsu_wb_ready is a function of registered occupancy and rst
// only (never of lsu_wb_valid). A transfer fires when lsu_wb_valid and
// lsu_wb_ready are both high at a rising clock edge; until it fires the LSU
// holds lsu_wb_addr/lsu_wb_data stable.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_wb_valid,
  input  logic [ADDR_W-1:0]             alu_wb_addr,
  input  logic [DATA_W-1:0]             alu_wb_data,
  input  logic                          lsu_wb_valid,
  output logic                          lsu_wb_ready,
  input  logic [ADDR_W-1:0]             lsu_wb_addr,
  input  logic [DATA_W-1:0]             lsu_wb_data,
  output logic                          rf_wr_en,
  output logic [ADDR_W-1:0]             rf_wr_addr,
  output logic [DATA_W-1:0]             rf_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [(2**ADDR_W)-1:0]        pending_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] entry_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] entry_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] entry_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] entry_data_d [FIFO_DEPTH];
  logic              entry_live_q [FIFO_DEPTH];
  logic              entry_live_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered write port
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;

  logic fifo_empty;
  logic lsu_fire;
  logic alu_win;
  logic lsu_keep;
  logic push;
  logic pop;

  assign fifo_empty   = (count_q == '0);
  assign lsu_wb_ready = (count_q < DEPTH_C) && !rst;
  assign lsu_fire     = lsu_wb_valid && lsu_wb_ready;
  // Writes to register 0 are accepted and dropped.
  assign alu_win      = alu_wb_valid && (alu_wb_addr != '0);
  // A same-cycle LSU result to the ALU's register is older, so it is dropped.
  assign lsu_keep     = lsu_fire && (lsu_wb_addr != '0) &&
                        !(alu_win && (lsu_wb_addr == alu_wb_addr));

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign fifo_count = count_q;

  // Port selection, squash, push and pop for the next cycle
  always_comb begin
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    entry_live_d = entry_live_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    pop          = 1'b0;
    push         = 1'b0;

    if (alu_win) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = alu_wb_addr;
      rf_wr_data_d = alu_wb_data;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (entry_addr_q[i] == alu_wb_addr) begin
          entry_live_d[i] = 1'b0;
        end
      end
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (entry_live_q[rd_ptr_q]) begin
        rf_wr_en_d   = 1'b1;
        rf_wr_addr_d = entry_addr_q[rd_ptr_q];
        rf_wr_data_d = entry_data_q[rd_ptr_q];
      end
      // Freed slots never contribute to pending_mask.
      entry_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (lsu_keep) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = lsu_wb_addr;
      rf_wr_data_d = lsu_wb_data;
    end

    // Everything kept from the LSU that was not bypassed goes into the FIFO.
    push = lsu_keep && !(fifo_empty && !alu_win);
    if (push) begin
      entry_addr_d[wr_ptr_q] = lsu_wb_addr;
      entry_data_d[wr_ptr_q] = lsu_wb_data;
      entry_live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // One-hot OR of the destination of every live queued entry
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_live_q[i]) begin
        pending_mask[entry_addr_q[i]] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry_addr_q[i] <= '0;
        entry_data_q[i] <= '0;
        entry_live_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      entry_addr_q <= entry_addr_d;
      entry_data_q <= entry_data_d;
      entry_live_q <= entry_live_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the writeback arbitration rules.
module tb_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int W     = 1 + AW + DW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          alu_wb_valid = 1'b0;
  logic [AW-1:0] alu_wb_addr  = '0;
  logic [DW-1:0] alu_wb_data  = '0;
  logic          lsu_wb_valid = 1'b0;
  logic          lsu_wb_ready;
  logic [AW-1:0] lsu_wb_addr  = '0;
  logic [DW-1:0] lsu_wb_data  = '0;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [(2**AW)-1:0]     pending_mask;

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .fifo_count(fifo_count), .pending_mask(pending_mask)
  );

  logic [W-1:0] got_w;
  assign got_w = {rf_wr_en, rf_wr_addr, rf_wr_data};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of pending LSU writes with a live flag each
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;
  ent_t          mq[$];
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_data = '0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_w;

  function automatic logic [(2**AW)-1:0] model_mask();
    logic [(2**AW)-1:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  // Applies the arbitration rules to the current inputs; queues the expected port value
  task automatic model_step();
    logic en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit alu_w, lsu_ok, was_empty;
    ent_t e;
    en = 1'b0;
    a  = m_last_addr;
    d  = m_last_data;
    if (rst) begin
      mq.delete();
      a = '0;
      d = '0;
    end else begin
      alu_w     = alu_wb_valid && (alu_wb_addr != 0);
      was_empty = (mq.size() == 0);
      lsu_ok    = lsu_wb_valid && (mq.size() < DEPTH) && (lsu_wb_addr != 0) &&
                  !(alu_w && lsu_wb_addr == alu_wb_addr);
      if (alu_w) begin
        en = 1'b1; a = alu_wb_addr; d = alu_wb_data;
        foreach (mq[i]) if (mq[i].addr == alu_wb_addr) mq[i].live = 1'b0;
      end else if (!was_empty) begin
        e = mq.pop_front();
        if (e.live) begin en = 1'b1; a = e.addr; d = e.data; end
      end else if (lsu_ok) begin
        en = 1'b1; a = lsu_wb_addr; d = lsu_wb_data;
        lsu_ok = 1'b0;
      end
      if (lsu_ok) begin
        e.addr = lsu_wb_addr; e.data = lsu_wb_data; e.live = 1'b1;
        mq.push_back(e);
      end
    end
    m_last_addr = a;
    m_last_data = d;
    exp_q.push_back({en, a, d});
  endtask

  // Driver: advance one clock; returns whether the LSU handshake completed
  task automatic cycle(output bit fired);
    fired = lsu_wb_valid && !rst && (mq.size() < DEPTH);
    model_step();
    @(posedge clk);
    #1;
    exp_w = exp_q.pop_front();
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
  endtask

  task automatic test_reset();
    bit f;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
    cycle(f);
    cycle(f);
    n_vec++;
    if (lsu_wb_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", lsu_wb_ready); end
    n_vec++;
    if (got_w !== '0) begin n_err++; $display("FAIL rst_port: got %h exp 0", got_w); end
    n_vec++;
    if (fifo_count !== 0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", fifo_count); end
    n_vec++;
    if (pending_mask !== 0) begin n_err++; $display("FAIL rst_mask: got %h exp 0", pending_mask); end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    n_vec++;
    if (lsu_wb_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b exp 1", lsu_wb_ready); end
  endtask

  task automatic test_bypass();
    bit f;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF);
    cycle(f);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_vec++;
    if (got_w !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL bypass_write: got en=%b a=%0d d=%h exp en=1 a=3 d=deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    n_vec++;
    if (fifo_count !== 0) begin n_err++; $display("FAIL bypass_count: got %0d exp 0", fifo_count); end
    cycle(f);
    n_vec++;
    if (got_w !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL bypass_idle_hold: got en=%b a=%0d d=%h exp en=0 a=3 d=deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
  endtask

  task automatic test_conflict();
    bit f;
    int k;
    logic [AW-1:0] seen[$];
    logic [DW-1:0] seen_d[$];
    k = 8;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'd5, 32'h11, k <= 13, AW'(k), 32'hA000_0000 + k);
      cycle(f);
      if (f) k++;
      n_vec++;
      if (got_w !== {1'b1, 5'd5, 32'h11}) begin
        n_err++; $display("FAIL conflict_alu[%0d]: got en=%b a=%0d d=%h exp en=1 a=5 d=11", c, rf_wr_en, rf_wr_addr, rf_wr_data);
      end
    end
    drive(1'b0, 5'd0, 32'h0, k <= 13, AW'(k), 32'hA000_0000 + k);
    #1;
    n_vec++;
    if (fifo_count !== 4) begin n_err++; $display("FAIL conflict_count: got %0d exp 4", fifo_count); end
    n_vec++;
    if (pending_mask !== 32'h0000_0F00) begin n_err++; $display("FAIL conflict_mask: got %h exp 00000f00", pending_mask); end
    n_vec++;
    if (lsu_wb_ready !== 1'b0) begin n_err++; $display("FAIL conflict_full_ready: got %b exp 0", lsu_wb_ready); end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 5'd0, 32'h0, k <= 13, AW'(k), 32'hA000_0000 + k);
      cycle(f);
      if (f) k++;
      if (rf_wr_en === 1'b1) begin seen.push_back(rf_wr_addr); seen_d.push_back(rf_wr_data); end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_vec++;
    if (seen.size() != 6) begin n_err++; $display("FAIL conflict_drain_len: got %0d exp 6", seen.size()); end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      n_vec++;
      if (seen[i] !== AW'(8 + i) || seen_d[i] !== 32'hA000_0000 + 8 + i) begin
        n_err++; $display("FAIL conflict_drain[%0d]: got a=%0d d=%h exp a=%0d d=%h", i, seen[i], seen_d[i], 8 + i, 32'hA000_0000 + 8 + i);
      end
    end
    n_vec++;
    if (fifo_count !== 0) begin n_err++; $display("FAIL conflict_empty: got %0d exp 0", fifo_count); end
  endtask

  task automatic test_squash();
    bit f;
    drive(1'b1, 5'd1, 32'h33, 1'b1, 5'd7, 32'h77);
    cycle(f);
    n_vec++;
    if (pending_mask !== 32'h0000_0080 || fifo_count !== 1) begin
      n_err++; $display("FAIL squash_queued: got mask=%h cnt=%0d exp mask=00000080 cnt=1", pending_mask, fifo_count);
    end
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
    cycle(f);
    n_vec++;
    if (got_w !== {1'b1, 5'd7, 32'h22}) begin
      n_err++; $display("FAIL squash_alu: got en=%b a=%0d d=%h exp en=1 a=7 d=22", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    n_vec++;
    if (pending_mask !== 0 || fifo_count !== 1) begin
      n_err++; $display("FAIL squash_mask: got mask=%h cnt=%0d exp mask=0 cnt=1", pending_mask, fifo_count);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(f);
    n_vec++;
    if (got_w !== {1'b0, 5'd7, 32'h22} || fifo_count !== 0) begin
      n_err++; $display("FAIL squash_pop: got en=%b a=%0d d=%h cnt=%0d exp en=0 a=7 d=22 cnt=0", rf_wr_en, rf_wr_addr, rf_wr_data, fifo_count);
    end
  endtask

  task automatic test_hazard();
    bit f;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h55);
    cycle(f);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_vec++;
    if (got_w !== {1'b1, 5'd4, 32'h44} || fifo_count !== 0) begin
      n_err++; $display("FAIL hazard_write: got en=%b a=%0d d=%h cnt=%0d exp en=1 a=4 d=44 cnt=0", rf_wr_en, rf_wr_addr, rf_wr_data, fifo_count);
    end
    cycle(f);
    n_vec++;
    if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL hazard_single: got en=%b exp 0", rf_wr_en); end
  endtask

  task automatic test_x0();
    bit f;
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    cycle(f);
    n_vec++;
    if (rf_wr_en !== 1'b0 || fifo_count !== 0) begin
      n_err++; $display("FAIL x0_empty: got en=%b cnt=%0d exp en=0 cnt=0", rf_wr_en, fifo_count);
    end
    drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd9, 32'h99);
    cycle(f);
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    cycle(f);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_vec++;
    if (got_w !== {1'b1, 5'd9, 32'h99} || fifo_count !== 0) begin
      n_err++; $display("FAIL x0_pop: got en=%b a=%0d d=%h cnt=%0d exp en=1 a=9 d=99 cnt=0", rf_wr_en, rf_wr_addr, rf_wr_data, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC);
    cycle(f);
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd13, 32'hD);
    cycle(f);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(f);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle(f);
      n_vec++;
      if (got_w !== '0 || fifo_count !== 0 || pending_mask !== 0) begin
        n_err++; $display("FAIL reset_mid[%0d]: got port=%h cnt=%0d mask=%h exp all 0", c, got_w, fifo_count, pending_mask);
      end
    end
  endtask

  task automatic test_random();
    bit f, have;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    have = 1'b0; la = '0; ld = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!have && $urandom_range(0, 9) < 6) begin
        have = 1'b1; la = AW'($urandom_range(0, 7)); ld = $urandom;
      end
      drive($urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)), $urandom, have, la, ld);
      #1;
      n_vec++;
      if (lsu_wb_ready !== (!rst && mq.size() < DEPTH) || fifo_count !== mq.size() ||
          pending_mask !== model_mask()) begin
        n_err++; $display("FAIL rand_state[%0d]: got rdy=%b cnt=%0d mask=%h exp rdy=%b cnt=%0d mask=%h", c,
                          lsu_wb_ready, fifo_count, pending_mask, !rst && mq.size() < DEPTH, mq.size(), model_mask());
      end
      cycle(f);
      if (f) have = 1'b0;
      n_vec++;
      if (got_w !== exp_w) begin
        n_err++; $display("FAIL rand_port[%0d]: got %h exp %h", c, got_w, exp_w);
      end
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_squash();
    test_hazard();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
